// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with a valid/ready token interface and a persistent {N,V,Z,C} flag register.
// Define ALU_MUL_EN to build the iterative shift-add multiply on opcode E; otherwise E is illegal.
module alu_pipe #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MUL_CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic             flags_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [3:0]       flags
);

  localparam int unsigned W1  = WIDTH + 1;
  localparam int unsigned MSB = WIDTH - 1;

  localparam int unsigned F_N = 3;
  localparam int unsigned F_V = 2;
  localparam int unsigned F_Z = 1;
  localparam int unsigned F_C = 0;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_ADC = 4'h8;
  localparam logic [3:0] OP_SBB = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_ASR = 4'hB;
  localparam logic [3:0] OP_ROL = 4'hC;
  localparam logic [3:0] OP_ROR = 4'hD;

  if ((WIDTH < 4) || ((2 ** MUL_CNT_W) <= WIDTH)) begin : g_bad_params
    $error("alu_pipe: WIDTH must be >= 4 and 2**MUL_CNT_W must exceed WIDTH");
  end

  logic             free_c;
  logic             accept_c;
  logic             cin_c;
  logic [W1-1:0]    add_full_c;
  logic [W1-1:0]    sub_full_c;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] data_c;
  logic             c_c;
  logic             v_c;
  logic             legal_c;
  logic [3:0]       alu_flags_c;

  logic             load_c;
  logic [WIDTH-1:0] load_data_c;
  logic             load_err_c;
  logic             load_upd_c;
  logic [3:0]       load_flags_c;

  assign free_c = !out_valid || out_ready;

  // Single-cycle datapath; carry/borrow-in comes from the live flag register
  always_comb begin
    cin_c      = ((in_op == OP_ADC) || (in_op == OP_SBB)) ? flags[F_C] : 1'b0;
    add_full_c = W1'(in_a) + W1'(in_b) + W1'(cin_c);
    sub_full_c = W1'(in_a) - W1'(in_b) - W1'(cin_c);
    res_c      = '0;
    c_c        = 1'b0;
    v_c        = 1'b0;
    legal_c    = 1'b1;
    case (in_op)
      OP_ADD, OP_ADC: begin
        res_c = add_full_c[MSB:0];
        c_c   = add_full_c[WIDTH];
        v_c   = (in_a[MSB] == in_b[MSB]) && (res_c[MSB] != in_a[MSB]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        res_c = sub_full_c[MSB:0];
        c_c   = sub_full_c[WIDTH];
        v_c   = (in_a[MSB] != in_b[MSB]) && (res_c[MSB] != in_a[MSB]);
      end
      OP_AND: res_c = in_a & in_b;
      OP_OR:  res_c = in_a | in_b;
      OP_XOR: res_c = in_a ^ in_b;
      OP_NOT: res_c = ~in_a;
      OP_SHL: begin
        res_c = {in_a[MSB-1:0], 1'b0};
        c_c   = in_a[MSB];
      end
      OP_SHR: begin
        res_c = {1'b0, in_a[MSB:1]};
        c_c   = in_a[0];
      end
      OP_ASR: begin
        res_c = {in_a[MSB], in_a[MSB:1]};
        c_c   = in_a[0];
      end
      OP_ROL: begin
        res_c = {in_a[MSB-1:0], in_a[MSB]};
        c_c   = in_a[MSB];
      end
      OP_ROR: begin
        res_c = {in_a[0], in_a[MSB:1]};
        c_c   = in_a[0];
      end
      default: legal_c = 1'b0;
    endcase
    data_c      = (in_op == OP_CMP) ? in_a : res_c;
    alu_flags_c = {res_c[MSB], v_c, ~|res_c, c_c};
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0]           OP_MUL   = 4'hE;
  localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(WIDTH - 1);
  localparam logic [MUL_CNT_W-1:0] CNT_SAT  = MUL_CNT_W'(WIDTH);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state;
  logic [MUL_CNT_W-1:0] mul_cnt;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mcand;
  logic [W1-1:0]        psum_c;
  logic [2*WIDTH-1:0]   prod_step_c;
  logic [2*WIDTH-1:0]   mul_prod_c;
  logic                 mul_start_c;
  logic                 mul_load_c;
  logic                 mul_ovf_c;

  // One shift-add step: add multiplicand into the high half when the current multiplier LSB is set
  always_comb begin
    psum_c      = W1'(prod[2*WIDTH-1:WIDTH]) + (prod[0] ? W1'(mcand) : W1'(0));
    prod_step_c = {psum_c, prod[MSB:1]};
    mul_prod_c  = (mul_cnt == CNT_SAT) ? prod : prod_step_c;
    mul_ovf_c   = |mul_prod_c[2*WIDTH-1:WIDTH];
    mul_start_c = accept_c && (in_op == OP_MUL);
    mul_load_c  = (state == BUSY) && (mul_cnt >= CNT_LAST) && free_c;
  end

  // Counter parks at CNT_SAT with the finished product held while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mul_cnt <= '0;
      prod    <= '0;
      mcand   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start_c) begin
            state   <= BUSY;
            mul_cnt <= '0;
            prod    <= {{WIDTH{1'b0}}, in_b};
            mcand   <= in_a;
          end
        end
        BUSY: begin
          if (mul_load_c) begin
            state   <= IDLE;
            mul_cnt <= '0;
          end else if (mul_cnt != CNT_SAT) begin
            prod    <= prod_step_c;
            mul_cnt <= mul_cnt + MUL_CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE) && free_c;
`else
  assign in_ready = free_c;
`endif

  assign accept_c = in_valid && in_ready;

  // Select what the output register loads this edge
  always_comb begin
    load_c       = accept_c;
    load_data_c  = data_c;
    load_err_c   = !legal_c;
    load_upd_c   = legal_c;
    load_flags_c = alu_flags_c;
`ifdef ALU_MUL_EN
    if (mul_start_c) begin
      load_c = 1'b0;
    end
    if (mul_load_c) begin
      load_c       = 1'b1;
      load_data_c  = mul_prod_c[MSB:0];
      load_err_c   = 1'b0;
      load_upd_c   = 1'b1;
      load_flags_c = {mul_prod_c[MSB], mul_ovf_c, ~|mul_prod_c[MSB:0], mul_ovf_c};
    end
`endif
  end

  // Output token and flag registers; a loading result's flags take priority over flags_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      flags     <= '0;
    end else begin
      if (load_c) begin
        out_valid <= 1'b1;
        out_data  <= load_data_c;
        out_err   <= load_err_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (load_c && load_upd_c) begin
        flags <= load_flags_c;
      end else if (flags_clr) begin
        flags <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe; an integer-arithmetic reference model predicts each token.
// Build with ALU_MUL_EN defined for both files to cover the multiply path.
module tb_alu_pipe;

  localparam int unsigned W = 8;
  localparam int M = 256;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
    logic [3:0]   fl;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   in_op;
  logic         flags_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;
  logic [3:0]   flags;

  exp_t       exp_q[$];
  int         n_chk;
  int         n_fail;
  logic [3:0] m_flags;
  bit         rand_rdy;

  alu_pipe #(.WIDTH(W), .MUL_CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .flags_clr (flags_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model in plain integer arithmetic on unsigned and signed interpretations
  function automatic exp_t model(input int a, input int b, input int op, input logic [3:0] fin);
    exp_t e;
    int   r, s, ss, sa, sb, ci;
    bit   c, v, legal;
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    ci = ((op == 8) || (op == 9)) ? int'(fin[0]) : 0;
    r = 0; c = 0; v = 0; legal = 1;
    case (op)
      0, 8: begin
        s = a + b + ci;     r = s % M;       c = (s >= M);
        ss = sa + sb + ci;  v = (ss > M / 2 - 1) || (ss < -(M / 2));
      end
      1, 9, 10: begin
        s = a - b - ci;     r = (s + M) % M; c = (a < b + ci);
        ss = sa - sb - ci;  v = (ss > M / 2 - 1) || (ss < -(M / 2));
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = M - 1 - a;
      6: begin r = (a * 2) % M;               c = (a >= M / 2); end
      7: begin r = a / 2;                     c = (a % 2 == 1); end
      11: begin r = a / 2 + (a / (M / 2)) * (M / 2); c = (a % 2 == 1); end
      12: begin r = (a * 2) % M + a / (M / 2); c = (a >= M / 2); end
      13: begin r = a / 2 + (a % 2) * (M / 2);  c = (a % 2 == 1); end
`ifdef ALU_MUL_EN
      14: begin s = a * b; r = s % M; c = (s >= M); v = c; end
`endif
      default: legal = 0;
    endcase
    if (!legal) begin
      e.data = '0;
      e.err  = 1'b1;
      e.fl   = fin;
    end else begin
      e.data = (op == 10) ? W'(a) : W'(r);
      e.err  = 1'b0;
      e.fl   = {r >= M / 2, v, r == 0, c};
    end
    return e;
  endfunction

  // Offer one token; on the cycle it will be accepted, predict and enqueue its result
  task automatic send(input int a, input int b, input int op);
    exp_t e;
    bit   ok;
    in_valid = 1'b1;
    in_a     = W'(a);
    in_b     = W'(b);
    in_op    = 4'(op);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(a, b, op, m_flags);
        m_flags = e.fl;
        exp_q.push_back(e);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: op 0x%0h never accepted", op);
    end
  endtask

  initial begin
    time  t0;
    int   cyc;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    flags_clr = 1'b0; out_ready = 1'b1; rand_rdy = 0; m_flags = '0;
    n_chk = 0; n_fail = 0;

    fork
      // Output monitor: compares every transferred token and checks stability while stalled
      begin
        exp_t         e;
        bit           hold_v;
        logic [W-1:0] hold_d;
        logic         hold_e;
        hold_v = 0; hold_d = '0; hold_e = 1'b0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            hold_v = 0;
          end else begin
            if (hold_v) begin
              check("stall_valid", 32'(out_valid), 32'd1);
              check("stall_data", 32'(out_data), 32'(hold_d));
              check("stall_err", 32'(out_err), 32'(hold_e));
            end
            if (out_valid && out_ready) begin
              if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: data 0x%0h with empty scoreboard", out_data);
              end else begin
                e = exp_q.pop_front();
                check("data", 32'(out_data), 32'(e.data));
                check("err", 32'(out_err), 32'(e.err));
                check("flags", 32'(flags), 32'(e.fl));
              end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_e = out_err;
          end
        end
      end
      // Random backpressure generator
      forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Carry out of the top bit, single-cycle latency, then chained ADC on the next cycle
    send(8'hFF, 8'h01, 0);
    t0 = $time;
    check("add_latency", 32'(out_valid), 32'd1);
    check("add_data", 32'(out_data), 32'h00);
    check("add_flags", 32'(flags), 32'b0011);
    send(8'h00, 8'h00, 8);
    check("adc_back_to_back", 32'($time - t0), 32'd10);
    check("adc_chain", 32'(out_data), 32'h01);

    send(8'h80, 8'h01, 1);
    check("sub_data", 32'(out_data), 32'h7F);
    check("sub_flags", 32'(flags), 32'b0100);
    send(8'h00, 8'h00, 9);
    check("sbb_flags", 32'(flags), 32'b0010);
    send(8'h01, 8'h02, 10);
    check("cmp_data", 32'(out_data), 32'h01);
    check("cmp_flags", 32'(flags), 32'b1001);

    send(8'h12, 8'h34, 15);
    check("illegal_err", 32'(out_err), 32'd1);
    check("illegal_data", 32'(out_data), 32'd0);
    check("illegal_flags", 32'(flags), 32'b1001);
    flags_clr = 1'b1;
    @(posedge clk);
    #1;
    flags_clr = 1'b0;
    m_flags = '0;
    check("flags_clr", 32'(flags), 32'd0);

    // Backpressure: a waiting token must not be taken while the output is stalled
    out_ready = 1'b0;
    send(5, 3, 0);
    fork
      send(7, 1, 1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send(8'h9C, 8'h0F, 4);
    send(8'h81, 8'h00, 13);

`ifdef ALU_MUL_EN
    repeat (2) @(posedge clk);
    #1;
    send(8'h10, 8'h10, 14);
    check("mul_busy_ready", 32'(in_ready), 32'd0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("mul_latency", 32'(cyc), 32'd9);
    check("mul_data", 32'(out_data), 32'h00);
    check("mul_flags", 32'(flags), 32'b0111);

    // Reset in the middle of a multiply discards it
    send(3, 5, 14);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_flags = '0;
    #1;
    check("mul_abort_valid", 32'(out_valid), 32'd0);
    check("mul_abort_flags", 32'(flags), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("mul_abort_ready", 32'(in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("mul_abort_no_output", 32'(out_valid), 32'd0);
`else
    send(8'h10, 8'h10, 14);
    check("op_e_illegal", 32'(out_err), 32'd1);
`endif

    // Randomized tokens under random backpressure
    rand_rdy = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)), int'($urandom_range(0, 15)));
    end
    rand_rdy = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parameterised, registered successor to the 8-bit combinational ALU. Accepts operand/opcode tokens over a valid/ready handshake and returns a registered result plus a persistent NZVC flag register. Adds carry-chained ops, compare, arithmetic shift and rotates. Sits between the decode stage and register-file writeback of the core datapath.

Parameters:
WIDTH, 8, operand/result width in bits (minimum 4)
MUL_CNT_W, 4, width of the multiply iteration counter; must satisfy 2**MUL_CNT_W > WIDTH

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operand token valid
in_ready  output  1  block can accept a token this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  4  opcode
flags_clr  input  1  synchronous clear of the flag register
out_valid  output  1  result token valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  result
out_err  output  1  illegal opcode for this token
flags  output  4  {N,V,Z,C} flag register

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_err=0, flags=0, FSM=IDLE, iteration counter=0. Any in-flight multiply is discarded.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(~a), 6 SHL(a<<1), 7 SHR(a>>1, logical), 8 ADC(a+b+C), 9 SBB(a-b-C), A CMP, B ASR(a>>>1), C ROL by 1, D ROR by 1, E MUL (optional), F illegal.
- Codes 0-7 produce results bit-identical to the 8-bit ALU at WIDTH=8.
- Handshake: token accepted when in_valid && in_ready. in_ready = (FSM==IDLE) && (!out_valid || out_ready). Output holds out_data/out_err stable while out_valid && !out_ready.
- Latency: single-cycle ops load the output register on the accept edge; out_valid is high the next cycle. Back-to-back throughput: 1 token/cycle while out_ready=1.
- Flags update on the same edge the output register loads, so the next ADC/SBB sees them.
- Z = (result==0). N = result[WIDTH-1].
- C for ADD/ADC: carry out of bit WIDTH-1. C for SUB/SBB/CMP: 1 on borrow (unsigned a < b + Cin).
- V for ADD/ADC/SUB/SBB/CMP: signed overflow. V for all other ops: 0.
- C for SHL/ROL: a[WIDTH-1]. C for SHR/ASR/ROR: a[0]. C for AND/OR/XOR/NOT: 0.
- CMP: flags as SUB; out_data = a (pass-through).
- Illegal opcode: out_data=0, out_err=1, flags unchanged; the token still completes the handshake.
- flags_clr: zeroes flags at the next edge. If the same edge also loads a result, the result's flags win.
- FSM states: IDLE, BUSY (MUL only), DONE-free design: single-cycle ops never leave IDLE.

Optional Feature:
ALU_MUL_EN:
- Defined:
  - Opcode E is an iterative shift-add unsigned multiply. On accept the FSM goes to BUSY for exactly WIDTH cycles with in_ready=0, then loads the low WIDTH bits of the product, returns to IDLE and raises out_valid WIDTH+1 cycles after accept.
  - C = V = (upper WIDTH product bits != 0). Z and N are taken from the low half.
  - If out_valid is still stalled when BUSY ends, the FSM waits in BUSY until the output register frees; the iteration counter saturates and does not wrap.
  - Reset mid-BUSY aborts with no output.
- Undefined: opcode E is illegal (out_err=1); no BUSY state or counter logic is synthesised.

Test Plan:
- WIDTH=8, ADD a=0xFF b=0x01 -> out_data=0x00, flags N0 V0 Z1 C1, out_valid exactly 1 cycle after accept.
- SUB a=0x80 b=0x01 -> 0x7F, V=1, C=0. Then SBB a=0x00 b=0x00 with C=0 -> 0x00, Z=1. Then CMP a=0x01 b=0x02 -> out_data=0x01, C=1, N=1.
- ADD 0xFF+0x01 followed back-to-back by ADC 0x00+0x00 -> second result 0x01 (carry chained), two results on consecutive cycles.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable, no token lost; release -> tokens drain in order.
- Opcode F -> out_err=1, out_data=0, flags unchanged. Assert flags_clr with no token -> flags=0 next cycle.
- ALU_MUL_EN, MUL 0x10*0x10 -> 0x00, C=1, V=1, Z=1, out_valid 9 cycles after accept. Drop rst_n at cycle 4 -> out_valid=0, flags=0, in_ready=1 after release.
